// File: rtl/reg_file_sb_pkg.sv
// Shared types and constants for the reg_file_sb register file and the
// 32:1 read-select MUX stage that consumes its packed register array.
package reg_file_sb_pkg;

    localparam int NREGS  = 32;   // fixed: must match the 5-bit MUX select
    localparam int WIDTH  = 20;
    localparam int ADDR_W = 5;    // log2(NREGS)

    typedef logic [WIDTH-1:0]              word_t;
    typedef logic [ADDR_W-1:0]             addr_t;
    typedef logic [NREGS-1:0][WIDTH-1:0]   reg_array_t;
    typedef logic [NREGS-1:0]              busy_vec_t;

    // Register 0 reads as zero and can be neither written nor reserved.
    localparam addr_t REG_ZERO = '0;

    function automatic logic is_writable(input addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_file_sb_mux.sv
// 32:1 x 20-bit read-select MUX. The register file instantiates it once per
// read port; the select is the register index, the data input the full array.
module reg_file_sb_mux
    import reg_file_sb_pkg::*;
(
    input  logic [NREGS-1:0][WIDTH-1:0] data_i,
    input  logic [ADDR_W-1:0]           sel_i,
    output logic [WIDTH-1:0]            data_o
);

    // Pure combinational select of one packed element.
    assign data_o = data_i[sel_i];

endmodule

// File: rtl/reg_file_sb.sv
// 32 x 20-bit register file with a busy-bit scoreboard, two combinational
// read ports (each through a reg_file_sb_mux), one write port and a stall
// output for the issue logic. Register 0 is hardwired to zero.
//
// Optional build macro READ_BYPASS_EN: when defined, a same-cycle write to a
// read port's address is forwarded onto that port's rd_data and removes that
// operand from the stall term. regs_out always shows the stored array.
module reg_file_sb
    import reg_file_sb_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    input  logic [ADDR_W-1:0]           rd_addr_a,
    input  logic                        rd_use_a,
    input  logic [ADDR_W-1:0]           rd_addr_b,
    input  logic                        rd_use_b,
    output logic [WIDTH-1:0]            rd_data_a,
    output logic [WIDTH-1:0]            rd_data_b,
    output logic [NREGS-1:0][WIDTH-1:0] regs_out,
    output logic [NREGS-1:0]            busy,
    output logic                        stall
);

    reg_array_t regs_q, regs_d;
    busy_vec_t  busy_q, busy_d;

    word_t      mux_a, mux_b;
    logic       byp_a, byp_b;

    // Next-state for storage and scoreboard: write first, then reservation,
    // so a same-address reserve overrides the writeback clear.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        regs_d = regs_q;
        busy_d = busy_q;

        if (wr_en && is_writable(wr_addr)) begin
            regs_d[wr_addr] = wr_data;
        end
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_en && is_writable(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end

        // Keep entry 0 constant so it folds away and can never read non-zero.
        regs_d[REG_ZERO] = '0;
        busy_d[REG_ZERO] = 1'b0;
    end

    // State registers with synchronous reset that overrides write and reserve.
    always_ff @(posedge clk) begin
        // NOTE: the register array is reset here on purpose: a reset must
        // clear all data and drop every pending reservation, so it is built
        // from flops rather than an unreset RAM macro.
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            // NOTE: non-blocking assignments for all flop updates so every
            // register samples its pre-edge inputs, independent of order.
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    assign regs_out = regs_q;
    assign busy     = busy_q;

    reg_file_sb_mux u_mux_a (
        .data_i (regs_q),
        .sel_i  (rd_addr_a),
        .data_o (mux_a)
    );

    reg_file_sb_mux u_mux_b (
        .data_i (regs_q),
        .sel_i  (rd_addr_b),
        .data_o (mux_b)
    );

`ifdef READ_BYPASS_EN
    // Forward the in-flight write to a port that reads the same register.
    assign byp_a = wr_en && is_writable(wr_addr) && (wr_addr == rd_addr_a);
    assign byp_b = wr_en && is_writable(wr_addr) && (wr_addr == rd_addr_b);
`else
    // Without forwarding a busy operand waits until the cycle after writeback.
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif

    assign rd_data_a = byp_a ? wr_data : mux_a;
    assign rd_data_b = byp_b ? wr_data : mux_b;

    // An operand stalls only if it is consumed, busy and not being forwarded.
    assign stall = (rd_use_a & busy_q[rd_addr_a] & ~byp_a) |
                   (rd_use_b & busy_q[rd_addr_b] & ~byp_b);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a table of one-cycle vectors with
// hand-computed expectations plus short sequences for reset, the full
// register sweep and the write-to-read bypass case.
module tb_reg_file_sb;
    import reg_file_sb_pkg::*;

`ifdef READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    addr_t      wr_addr;
    word_t      wr_data;
    logic       rsv_en;
    addr_t      rsv_addr;
    addr_t      rd_addr_a;
    logic       rd_use_a;
    addr_t      rd_addr_b;
    logic       rd_use_b;
    word_t      rd_data_a;
    word_t      rd_data_b;
    reg_array_t regs_out;
    busy_vec_t  busy;
    logic       stall;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_file_sb dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .rd_addr_a (rd_addr_a),
        .rd_use_a  (rd_use_a),
        .rd_addr_b (rd_addr_b),
        .rd_use_b  (rd_use_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .regs_out  (regs_out),
        .busy      (busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [639:0] act, input logic [639:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        rsv_en    = 1'b0;
        rsv_addr  = '0;
        rd_addr_a = '0;
        rd_use_a  = 1'b0;
        rd_addr_b = '0;
        rd_use_b  = 1'b0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic      wr_en;
        addr_t     wr_addr;
        word_t     wr_data;
        logic      rsv_en;
        addr_t     rsv_addr;
        addr_t     ra_a;
        logic      ua;
        addr_t     ra_b;
        logic      ub;
        word_t     exp_a;
        word_t     exp_b;
        logic      exp_stall;
        busy_vec_t exp_busy;
    } vec_t;

    vec_t vecs[18];
    reg_array_t exp_regs;

    initial begin
        // Expectations are the outputs seen before the vector's own edge.
        //            we  wa  wd        rsv ra  raa ua  rab ub  exp_a     exp_b     st  busy
        vecs[0]  = '{1, 5, 20'hABCDE, 0, 0,  5, 0,  0, 0, BYP ? 20'hABCDE : 20'h0, 20'h0, 0, 32'h0};
        vecs[1]  = '{0, 0, 20'h0,     0, 0,  5, 0,  5, 0, 20'hABCDE, 20'hABCDE, 0, 32'h0};
        vecs[2]  = '{1, 0, 20'hFFFFF, 1, 0,  0, 1,  0, 0, 20'h0,     20'h0,     0, 32'h0};
        vecs[3]  = '{0, 0, 20'h0,     0, 0,  0, 1,  5, 1, 20'h0,     20'hABCDE, 0, 32'h0};
        vecs[4]  = '{0, 0, 20'h0,     1, 7,  0, 0,  7, 1, 20'h0,     20'h0,     0, 32'h0};
        vecs[5]  = '{0, 0, 20'h0,     0, 0,  0, 0,  7, 1, 20'h0,     20'h0,     1, 32'h80};
        vecs[6]  = '{0, 0, 20'h0,     0, 0,  0, 0,  7, 0, 20'h0,     20'h0,     0, 32'h80};
        vecs[7]  = '{1, 7, 20'h00042, 0, 0,  0, 0,  5, 0, 20'h0,     20'hABCDE, 0, 32'h80};
        vecs[8]  = '{0, 0, 20'h0,     0, 0,  0, 0,  7, 1, 20'h0,     20'h00042, 0, 32'h0};
        vecs[9]  = '{1, 9, 20'h11111, 1, 9,  1, 0,  0, 0, 20'h0,     20'h0,     0, 32'h0};
        vecs[10] = '{0, 0, 20'h0,     0, 0,  9, 1,  0, 0, 20'h11111, 20'h0,     1, 32'h200};
        vecs[11] = '{0, 0, 20'h0,     1, 10, 9, 0,  0, 0, 20'h11111, 20'h0,     0, 32'h200};
        vecs[12] = '{1, 10, 20'h22222, 1, 9, 3, 0,  9, 1, 20'h0,     20'h11111, 1, 32'h600};
        vecs[13] = '{0, 0, 20'h0,     0, 0,  10, 1, 9, 0, 20'h22222, 20'h11111, 0, 32'h200};
        vecs[14] = '{0, 0, 20'h0,     1, 9,  0, 0,  9, 1, 20'h0,     20'h11111, 1, 32'h200};
        vecs[15] = '{0, 0, 20'h0,     0, 0,  0, 0,  9, 1, 20'h0,     20'h11111, 1, 32'h200};
        vecs[16] = '{1, 9, 20'h33333, 0, 0,  5, 1,  0, 0, 20'hABCDE, 20'h0,     0, 32'h200};
        vecs[17] = '{0, 0, 20'h0,     0, 0,  7, 1,  9, 1, 20'h00042, 20'h33333, 0, 32'h0};

        // Reset from power-up.
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rd_addr_a = 5'd3;
        rd_use_a  = 1'b1;
        @(negedge clk);
        check("por regs_out", regs_out, '0);
        check("por busy", busy, '0);
        check("por stall", stall, 1'b0);

        // Write r3, then reset clears it.
        next_cycle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 20'h12345; rd_use_a = 1'b0;
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("r3 before reset", rd_data_a, 20'h12345);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset regs_out", regs_out, '0);
        check("reset busy", busy, '0);
        check("reset rd_data_a", rd_data_a, 20'h0);

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 18; i++) begin
            next_cycle();
            wr_en     = vecs[i].wr_en;
            wr_addr   = vecs[i].wr_addr;
            wr_data   = vecs[i].wr_data;
            rsv_en    = vecs[i].rsv_en;
            rsv_addr  = vecs[i].rsv_addr;
            rd_addr_a = vecs[i].ra_a;
            rd_use_a  = vecs[i].ua;
            rd_addr_b = vecs[i].ra_b;
            rd_use_b  = vecs[i].ub;
            @(negedge clk);
            check($sformatf("v%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
            check($sformatf("v%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
            check($sformatf("v%0d stall", i), stall, vecs[i].exp_stall);
            check($sformatf("v%0d busy", i), busy, vecs[i].exp_busy);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("r0 regs_out[0]", regs_out[0], 20'h0);

        // Sweep: write r1..r31 = i, then read back on both ports.
        exp_regs = '0;
        for (int i = 1; i < NREGS; i++) begin
            next_cycle();
            wr_en   = 1'b1;
            wr_addr = addr_t'(i);
            wr_data = word_t'(i);
            exp_regs[i] = word_t'(i);
        end
        next_cycle();
        idle_inputs();
        for (int i = 1; i < NREGS; i++) begin
            rd_addr_a = addr_t'(i);
            rd_addr_b = addr_t'(NREGS - i);
            #1;
            check($sformatf("sweep a r%0d", i), rd_data_a, word_t'(i));
            check($sformatf("sweep b r%0d", NREGS - i), rd_data_b, word_t'(NREGS - i));
        end
        check("sweep regs_out", regs_out, exp_regs);

        // Busy r4 written while being read on port A.
        next_cycle();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd4;
        next_cycle();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 20'h0BEEF;
        rd_addr_a = 5'd4; rd_use_a = 1'b1;
        @(negedge clk);
        check("bypass rd_data_a", rd_data_a, BYP ? 20'h0BEEF : 20'h00004);
        check("bypass stall", stall, BYP ? 1'b0 : 1'b1);
        check("bypass regs_out[4]", regs_out[4], 20'h00004);
        check("bypass busy", busy, 32'h10);
        next_cycle();
        wr_en = 1'b0;
        @(negedge clk);
        check("post-wb rd_data_a", rd_data_a, 20'h0BEEF);
        check("post-wb stall", stall, 1'b0);
        check("post-wb busy", busy, 32'h0);

        // Reset mid-operation drops reservations and overrides write/reserve.
        next_cycle();
        idle_inputs();
        rsv_en = 1'b1; rsv_addr = 5'd12;
        next_cycle();
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd13; wr_data = 20'h55555;
        rsv_en = 1'b1; rsv_addr = 5'd14;
        @(negedge clk);
        check("pre-reset busy", busy, 32'h1000);
        next_cycle();
        rst = 1'b0;
        idle_inputs();
        rd_addr_a = 5'd12; rd_use_a = 1'b1;
        rd_addr_b = 5'd14; rd_use_b = 1'b1;
        @(negedge clk);
        check("mid reset regs_out", regs_out, '0);
        check("mid reset busy", busy, '0);
        check("mid reset stall", stall, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- 32-entry x 20-bit general register file with a busy-bit scoreboard.
- Sits directly upstream of the 32:1 20-bit MUX read-select stage; the full register array drives the MUX data input.
- Provides two read ports built from MUX instances, one write port, and a stall signal for the issue logic.

Parameters:
- NREGS, 32, number of registers; must stay 32 to match the 5-bit MUX select.
- WIDTH, 20, register data width in bits.
- ADDR_W, 5, register address width; equals log2(NREGS).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request, sampled at posedge.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  WIDTH  write data.
- rsv_en  input  1  reserve request: marks the destination busy at issue.
- rsv_addr  input  ADDR_W  register to reserve.
- rd_addr_a  input  ADDR_W  read port A index (MUX select).
- rd_use_a  input  1  port A operand is actually consumed this cycle.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_use_b  input  1  port B operand is consumed.
- rd_data_a  output  WIDTH  port A read data (combinational).
- rd_data_b  output  WIDTH  port B read data (combinational).
- regs_out  output  NREGS x WIDTH  packed register array, element i = register i; feeds the MUX data input.
- busy  output  NREGS  scoreboard vector, bit i = register i awaiting writeback.
- stall  output  1  an in-use operand is busy.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high.
  - On a posedge with rst=1, every register clears to 0 and busy clears to 0.
  - rst overrides wr_en and rsv_en in the same cycle.
  - Reset mid-operation discards all pending reservations.
  - Outputs follow from the cleared state: regs_out=0, rd_data=0, stall=0.
- Register 0 is hardwired to zero:
  - Writes to addr 0 are ignored.
  - rsv to addr 0 is ignored.
  - busy[0] is always 0.
- Write:
  - On a posedge with wr_en=1 and wr_addr!=0, regs[wr_addr] <= wr_data.
  - The new value is visible on regs_out and rd_data one cycle after the edge (1-cycle write latency).
- Read: rd_data_x = regs[rd_addr_x], purely combinational through the MUX instance; zero cycles from an address change.
- Scoreboard:
  - A posedge with wr_en=1 clears busy[wr_addr].
  - A posedge with rsv_en=1 sets busy[rsv_addr].
  - Same edge, same address: set wins (new producer) and busy stays 1.
  - Same edge, different addresses: both the set and the clear apply.
  - Reserving an already-busy register keeps it at 1; WAW is allowed and no counting is done.
  - A write to a non-busy register is legal: data is written and busy stays 0.
- Stall is combinational: stall = (rd_use_a & busy[rd_addr_a]) | (rd_use_b & busy[rd_addr_b]).
- No internal FSM beyond the storage and busy flops; all sequential state is regs[1..31] and busy[1..31].

Optional Feature:
- Macro: READ_BYPASS_EN.
- Defined, write-to-read bypass:
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addr_x, then rd_data_x = wr_data in the same cycle.
  - That operand does not contribute to stall, even if busy.
  - regs_out is not bypassed.
- Undefined:
  - rd_data is always taken from the stored array.
  - A busy operand stalls until the cycle after its writeback.

Decomposition:
- Shared package:
  - WIDTH=20, NREGS=32 and ADDR_W=5 constants.
  - A word_t typedef of 20 bits.
  - A reg_array_t typedef, packed [31:0][19:0], shared with the MUX stage.
  - A REG_ZERO index constant.
- Sub-module: reuse the existing 32:1 MUX twice, for read ports A and B. The bypass select is a small mux in this block's top level.
- Storage and scoreboard stay in one module.

Test Plan:
- Reset: write 20'h12345 to r3, then assert rst for 1 cycle -> regs_out all 0, busy=0, rd_data_a(addr 3)=0.
- Write/read: write r5=20'hABCDE -> rd_data_a(addr 5) is 0 in the edge cycle and 20'hABCDE from the next cycle. r1–r31 distinct patterns 20'h00000+i read back on both ports.
- R0: wr_en to addr 0 with 20'hFFFFF, plus rsv addr 0 -> regs_out[0]=0, busy[0]=0, stall=0 with rd_use_a on addr 0.
- Scoreboard: rsv r7 -> busy[7]=1 and stall=1 with rd_addr_b=7, rd_use_b=1. stall=0 with rd_use_b=0. Write r7=20'h00042 -> busy[7]=0 next cycle, rd_data_b=20'h00042.
- Simultaneous: rsv r9 and write r9 on the same edge -> busy[9]=1 and r9 updated. rsv r9 plus write r10 (busy[10]=1) on one edge -> busy[9]=1, busy[10]=0.
- Bypass (READ_BYPASS_EN): r4 busy, wr r4=20'h0BEEF with rd_addr_a=4, rd_use_a=1 -> same cycle rd_data_a=20'h0BEEF, stall=0. Without the macro -> stall=1 and old r4 value.
